// File: rtl/p_mul_result_serializer_if.sv
// Handshake bundle between the multiplier output, the serializer and the beat sink.
//   in_valid/in_data : full-width product from the multiplier (no backpressure)
//   out_ready        : sink accepts the current beat
//   out_valid/out_data/out_last : beat stream, least-significant beat first
// master: the environment side (multiplier + sink); slave: the serializer.
interface p_mul_result_serializer_if #(
  parameter int unsigned DW = 96,
  parameter int unsigned BW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/p_mul_result_serializer.sv
// Buffers full-width multiplier products in a small FIFO and streams each one
// out as BW-bit beats, least-significant beat first. Products arriving while
// the FIFO is full (and no head pop happens that cycle) are dropped and flagged.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : slave side of p_mul_result_serializer_if
//   overflow    : sticky drop flag, cleared only by reset
//   fifo_count  : products stored, including the one being streamed
module p_mul_result_serializer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 96,
  parameter int unsigned BW    = 16,
  parameter int unsigned BEATS = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  p_mul_result_serializer_if.slave     bus,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned BCW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [DW-1:0]  mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [BCW-1:0] beat;

  logic          out_valid_c;
  logic          out_last_c;
  logic          hs_c;
  logic          pop_c;
  logic          push_c;
  logic          drop_c;
  logic [DW-1:0] head_c;

  // Handshake decode; outputs depend only on registered state.
  always_comb begin
    out_valid_c = (count != '0);
    out_last_c  = out_valid_c && (beat == BCW'(BEATS - 1));
    hs_c        = out_valid_c && bus.out_ready;
    pop_c       = hs_c && out_last_c;
    // A full FIFO still accepts when the head frees its slot this cycle.
    push_c      = bus.in_valid && ((count < CW'(DEPTH)) || pop_c);
    drop_c      = bus.in_valid && !push_c;
    head_c      = mem[rd_ptr];
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = out_valid_c ? head_c[32'(beat) * BW +: BW] : '0;
  assign fifo_count    = count;

  // Storage needs no reset; contents are only read while count != 0.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy, beat position and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
        beat   <= '0;
      end else if (hs_c) begin
        beat <= beat + BCW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_p_mul_result_serializer.sv
// Self-checking bench for p_mul_result_serializer: a scoreboard queue holds
// expected {last, data} beats, filled when products are driven and drained by
// a negedge monitor on each handshake. Scenario tasks add inline checks.
module tb_p_mul_result_serializer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 96;
  localparam int unsigned BW    = 16;
  localparam int unsigned BEATS = 6;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic overflow;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  p_mul_result_serializer_if #(.DW(DW), .BW(BW)) bus ();

  p_mul_result_serializer #(
    .DEPTH(DEPTH), .DW(DW), .BW(BW), .BEATS(BEATS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  int max_count = 0;

  logic [BW:0]   exp_q[$];
  logic          held_valid = 1'b0;
  logic [BW-1:0] held_data;
  logic          held_last;

  localparam logic [DW-1:0] P0 = 96'h0123_4567_89AB_CDEF_FEDC_BA98;

  // Monitor: checks every handshake against the scoreboard and stall stability.
  always @(negedge clk) begin
    logic [BW:0] e;
    if (rst_n === 1'b1) begin
      if (held_valid) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held_data || bus.out_last !== held_last) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                   bus.out_valid, bus.out_data, bus.out_last, held_data, held_last);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h last=%b, need no beat", bus.out_data, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            errors++;
            $display("FAIL beat: got last=%b data=%h, need last=%b data=%h",
                     bus.out_last, bus.out_data, e[BW], e[BW-1:0]);
          end
        end
      end
      held_valid = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      held_data  = bus.out_data;
      held_last  = bus.out_last;
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic push_product(input logic [DW-1:0] p);
    for (int b = 0; b < BEATS; b++) begin
      logic l;
      l = (b == BEATS - 1);
      exp_q.push_back({l, p[b*BW +: BW]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && bus.out_valid === 1'b0) break;
      step();
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats left valid=%b, need 0 left valid=0",
               name, exp_q.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid); end
    if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h need 0", bus.out_data); end
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b need 0", bus.out_last); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b need 0", overflow); end
    if (fifo_count !== '0) begin errors++; $display("FAIL reset_fifo_count: got %0d need 0", fifo_count); end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = P0;
    push_product(P0);
    step();
    bus.in_valid = 1'b0;
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency_valid: got %b need 1", bus.out_valid); end
    if (bus.out_data !== 16'hBA98) begin errors++; $display("FAIL single_first_beat: got %h need ba98", bus.out_data); end
    if (fifo_count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d need 1", fifo_count); end
    wait_drain("single");
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b need 0", bus.out_valid); end
    if (bus.out_data !== '0) begin errors++; $display("FAIL single_idle_data: got %h need 0", bus.out_data); end
    if (fifo_count !== '0) begin errors++; $display("FAIL single_idle_count: got %0d need 0", fifo_count); end
  endtask

  task automatic test_backpressure();
    hs_count = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = P0;
    bus.out_ready = 1'b1;
    push_product(P0);
    for (int i = 1; i < 60; i++) begin
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = (i % 3 == 0);
    end
    wait_drain("backpressure");
    checks++;
    if (hs_count != BEATS) begin
      errors++;
      $display("FAIL backpressure_handshakes: got %0d need %0d", hs_count, BEATS);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_burst_fill();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 5) begin
        checks += 2;
        if (fifo_count !== CW'(4)) begin errors++; $display("FAIL burst_full_count: got %0d need 4", fifo_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL burst_no_overflow: got %b need 0", overflow); end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(k);
      if (k <= 4) push_product(DW'(k));
    end
    step();
    bus.in_valid = 1'b0;
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow: got %b need 1", overflow); end
    if (fifo_count !== CW'(4)) begin errors++; $display("FAIL burst_drop_count: got %0d need 4", fifo_count); end
    bus.out_ready = 1'b1;
    wait_drain("burst");
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL burst_sticky: got %b need 1", overflow); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    q = {$urandom, $urandom, $urandom};
    r = {$urandom, $urandom, $urandom};
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = q;
    push_product(q);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    checks++;
    if (bus.out_data !== q[3*BW +: BW]) begin
      errors++;
      $display("FAIL midreset_beat3: got %h need %h", bus.out_data, q[3*BW +: BW]);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b need 0", bus.out_valid); end
    if (bus.out_data !== '0) begin errors++; $display("FAIL midreset_data: got %h need 0", bus.out_data); end
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL midreset_last: got %b need 0", bus.out_last); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow: got %b need 0", overflow); end
    if (fifo_count !== '0) begin errors++; $display("FAIL midreset_count: got %0d need 0", fifo_count); end
    step();
    rst_n = 1'b1;
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = r;
    push_product(r);
    step();
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.out_data !== r[BW-1:0]) begin errors++; $display("FAIL midreset_fresh_beat0: got %h need %h", bus.out_data, r[BW-1:0]); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_fresh_overflow: got %b need 0", overflow); end
    wait_drain("midreset");
  endtask

  task automatic test_full_pop();
    bus.out_ready = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      step();
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(k);
      push_product(DW'(k));
    end
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
    checks += 2;
    if (bus.out_last !== 1'b1) begin errors++; $display("FAIL fullpop_head_last: got %b need 1", bus.out_last); end
    if (fifo_count !== CW'(4)) begin errors++; $display("FAIL fullpop_pre_count: got %0d need 4", fifo_count); end
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(9);
    push_product(DW'(9));
    step();
    bus.in_valid = 1'b0;
    checks += 2;
    if (fifo_count !== CW'(4)) begin errors++; $display("FAIL fullpop_count: got %0d need 4", fifo_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b need 0", overflow); end
    wait_drain("fullpop");
  endtask

  task automatic test_back_to_back();
    int gaps;
    gaps = 0;
    max_count = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (c > 0 && bus.out_valid !== 1'b1) gaps++;
      bus.in_valid = (c % 6 == 0);
      if (c % 6 == 0) begin
        bus.in_data = {$urandom, $urandom, $urandom};
        push_product(bus.in_data);
      end
    end
    step();
    bus.in_valid = 1'b0;
    wait_drain("b2b");
    checks += 2;
    if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d need 0", gaps); end
    if (max_count > 1) begin errors++; $display("FAIL b2b_max_count: got %0d need <=1", max_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_burst_fill();
    test_mid_reset();
    test_full_pop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/p_mul_result_serializer.md
# p_mul_result_serializer

Downstream stage of the pipelined 96-bit product multiplier. It accepts full-width products, one per cycle at most, from the multiplier's `out`/`out_valid` pair, which has no backpressure. It buffers them in a small FIFO and streams each product out as 16-bit beats over a valid/ready handshake, least-significant beat first. Products that arrive while the FIFO is full are dropped and flagged.

## Interface
- DEPTH, 4, FIFO capacity in whole products; power of two, ≥2
- DW, 96, product width; must equal BEATS*BW
- BW, 16, output beat width
- BEATS, 6, beats per product (DW/BW)
- clk  input  1  clock, rising-edge
- rst_n  input  1  reset; asynchronous, active-low; reset rst_n, asynchronous, active-low; clock clk
- in_valid  input  1  product present on in_data this cycle; driven by multiplier out_valid
- in_data  input  DW  product; driven by multiplier out
- out_ready  input  1  sink accepts the current beat
- out_valid  output  1  beat on out_data is valid
- out_data  output  BW  current beat
- out_last  output  1  current beat is beat BEATS-1 of its product
- overflow  output  1  sticky; a product was dropped because the FIFO was full
- fifo_count  output  $clog2(DEPTH+1)  number of products stored, including the one being streamed

## Operation
- Storage: DEPTH×DW register array with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy counter `count` drives fifo_count.
- Beat counter `beat`: 0..BEATS-1, indexes the head entry.
- pop = out_valid && out_ready && out_last. This is the last-beat handshake and it frees the head entry.
- push = in_valid && (count < DEPTH || pop).
  - If the FIFO is full but the head's last beat is handed off in the same cycle, the incoming product is accepted.
- drop = in_valid && !push. On drop, overflow is set to 1. Only reset clears it.
- count_next = count + push − pop. Simultaneous push and pop leaves count unchanged. A push into an empty FIFO with no pop gives count 1.
- Beat counter:
  - On out_valid && out_ready: beat advances by 1.
  - On out_last handshake: beat returns to 0 and rd_ptr advances.
  - With no handshake: beat holds.
- Outputs, decoded from registers only, with no combinational path from in_valid or out_ready:
  - out_valid = (count != 0).
  - out_data = head[beat*BW +: BW] when count != 0, else 0.
  - out_last = out_valid && (beat == BEATS-1).
- Stability: while out_valid && !out_ready, out_data and out_last hold. A push arriving at the same time does not disturb the head entry.
- Order: products leave in arrival order. Beat k of a product carries bits [16k+15:16k].
- Arithmetic: no transformation of data. The block only buffers and slices.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, overflow 0, fifo_count 0. Pointers and beat are 0. Storage contents are don't-care.
- Reset asserted mid-stream: everything is flushed immediately (asynchronous clear). Partially sent products are lost. After release, the first in_valid is treated as a fresh product.
- Latency: a product sampled with in_valid at edge N into an empty FIFO gives out_valid=1 and beat 0 on out_data in the cycle after edge N.
- Throughput: with out_ready held high, one beat per cycle, i.e. one product per BEATS cycles. There are no bubble cycles between products.
- overflow rises in the cycle after the edge at which the drop occurred.
- fifo_count updates at the same edge as the push or pop.

## Test plan
- Single product: reset, then in_valid for one cycle with in_data=96'h0123_4567_89AB_CDEF_FEDC_BA98 and out_ready=1.
  - out_valid rises the next cycle.
  - Beats are 16'hBA98, FEDC, CDEF, 89AB, 4567, 0123, with out_last only on 16'h0123.
  - Then out_valid=0, out_data=0, fifo_count=0.
- Backpressure: same product with out_ready toggling 1,0,0,1,…
  - Each beat holds stable while out_ready=0.
  - Exactly 6 handshakes occur; beat order is unchanged.
- Burst fill: out_ready=0, then 4 consecutive in_valid products with values 1, 2, 3, 4.
  - fifo_count reaches 4; overflow stays 0.
  - A 5th product (value 5) is dropped and overflow goes to 1.
  - Releasing out_ready streams 1, 2, 3, 4 in order; 5 never appears.
- Full plus simultaneous pop: FIFO full, head on beat 5, out_ready=1 and in_valid=1 (value 9) in the same cycle.
  - The product is accepted, fifo_count stays 4, overflow stays 0.
  - 9 appears later, after the three older products.
- Back-to-back streaming: 10 products at one every 6 cycles, out_ready=1.
  - Output is continuous with no gaps; fifo_count never exceeds 1; pointers wrap correctly past DEPTH.
- Mid-stream reset: assert rst_n=0 during beat 3 of a product.
  - All outputs go to 0 immediately.
  - After release, a new product streams from beat 0 with overflow=0.
